// File: rtl/axi_tx.sv
// AXI-Stream to serial transmitter: one-entry holding register, MSB-first shifter, divided sclk.
// Optional macro TX_TLAST_GAP_EN inserts GAP_SCLKS idle sclk periods after every tlast packet.
module axi_tx #(
  parameter int PACKET_LENGTH = 32,
  parameter int CLK_DIV       = 2,
  parameter int GAP_SCLKS     = 4
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [PACKET_LENGTH-1:0] s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic                     sclk,
  output logic                     sdata,
  output logic                     svalid,
  output logic                     busy
);

  localparam int BW = (PACKET_LENGTH > 1) ? $clog2(PACKET_LENGTH) : 1;
  localparam logic [BW-1:0] BIT_TOP = BW'(PACKET_LENGTH - 1);
  localparam logic [7:0]    DIV_TOP = 8'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef TX_TLAST_GAP_EN
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [3:0] GAP_TOP  = 4'(GAP_SCLKS - 1);
`endif

  logic [1:0]               state_r, state_n;
  logic [7:0]               div_cnt_r, div_cnt_n;
  logic [PACKET_LENGTH-1:0] shreg_r, shreg_n;
  logic [BW-1:0]            bit_cnt_r, bit_cnt_n;
  logic [PACKET_LENGTH-1:0] hold_data_r, hold_data_n;
  logic                     hold_full_r, hold_full_n;
  logic                     sclk_n, sdata_n, svalid_n, tready_n, busy_n;
  logic                     rise_s, capture_s, load_s;
`ifdef TX_TLAST_GAP_EN
  logic                     hold_last_r, hold_last_n;
  logic                     last_r, last_n;
  logic [3:0]               gap_cnt_r, gap_cnt_n;
`else
  logic                     unused_s;
  assign unused_s = s_tlast & (GAP_SCLKS > 0);
`endif

  // Next-state logic: sclk divider, serialiser FSM and holding register
  always_comb begin
    state_n     = state_r;
    div_cnt_n   = div_cnt_r + 8'd1;
    sclk_n      = sclk;
    shreg_n     = shreg_r;
    bit_cnt_n   = bit_cnt_r;
    hold_data_n = hold_data_r;
    hold_full_n = hold_full_r;
    sdata_n     = sdata;
    svalid_n    = svalid;
    load_s      = 1'b0;
`ifdef TX_TLAST_GAP_EN
    hold_last_n = hold_last_r;
    last_n      = last_r;
    gap_cnt_n   = gap_cnt_r;
`endif
    if (div_cnt_r == DIV_TOP) begin
      div_cnt_n = 8'd0;
      sclk_n    = ~sclk;
    end else begin
      div_cnt_n = div_cnt_r + 8'd1;
    end
    rise_s    = (div_cnt_r == DIV_TOP) && !sclk;
    capture_s = s_tvalid && s_tready;

    // Serial outputs only move on the aclk edge where sclk rises
    if (rise_s) begin
      case (state_r)
        ST_IDLE: begin
          if (hold_full_r) begin
            load_s = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_r != {BW{1'b0}}) begin
            shreg_n   = {shreg_r[PACKET_LENGTH-2:0], 1'b0};
            sdata_n   = shreg_r[PACKET_LENGTH-2];
            bit_cnt_n = bit_cnt_r - BW'(1);
`ifdef TX_TLAST_GAP_EN
          end else if (last_r) begin
            state_n   = ST_GAP;
            gap_cnt_n = 4'd0;
            sdata_n   = 1'b0;
            svalid_n  = 1'b0;
`endif
          end else if (hold_full_r) begin
            load_s = 1'b1;
          end else begin
            state_n  = ST_IDLE;
            sdata_n  = 1'b0;
            svalid_n = 1'b0;
          end
        end
`ifdef TX_TLAST_GAP_EN
        ST_GAP: begin
          if (gap_cnt_r != GAP_TOP) begin
            gap_cnt_n = gap_cnt_r + 4'd1;
          end else if (hold_full_r) begin
            load_s = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
`endif
        default: begin
          state_n  = ST_IDLE;
          sdata_n  = 1'b0;
          svalid_n = 1'b0;
        end
      endcase
    end else begin
      state_n = state_r;
    end

    if (load_s) begin
      state_n     = ST_SHIFT;
      shreg_n     = hold_data_r;
      sdata_n     = hold_data_r[PACKET_LENGTH-1];
      svalid_n    = 1'b1;
      bit_cnt_n   = BIT_TOP;
      hold_full_n = 1'b0;
`ifdef TX_TLAST_GAP_EN
      last_n      = hold_last_r;
`endif
    end else begin
      hold_full_n = hold_full_r;
    end

    // Capture and load are exclusive: s_tready is low whenever the holder is full
    if (capture_s) begin
      hold_full_n = 1'b1;
      hold_data_n = s_tdata;
`ifdef TX_TLAST_GAP_EN
      hold_last_n = s_tlast;
`endif
    end else begin
      hold_data_n = hold_data_r;
    end

    tready_n = !hold_full_n;
    busy_n   = (state_n != ST_IDLE) || hold_full_n;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r     <= ST_IDLE;
      div_cnt_r   <= 8'd0;
      sclk        <= 1'b0;
      shreg_r     <= {PACKET_LENGTH{1'b0}};
      bit_cnt_r   <= {BW{1'b0}};
      hold_data_r <= {PACKET_LENGTH{1'b0}};
      hold_full_r <= 1'b0;
      sdata       <= 1'b0;
      svalid      <= 1'b0;
      s_tready    <= 1'b0;
      busy        <= 1'b0;
`ifdef TX_TLAST_GAP_EN
      hold_last_r <= 1'b0;
      last_r      <= 1'b0;
      gap_cnt_r   <= 4'd0;
`endif
    end else begin
      state_r     <= state_n;
      div_cnt_r   <= div_cnt_n;
      sclk        <= sclk_n;
      shreg_r     <= shreg_n;
      bit_cnt_r   <= bit_cnt_n;
      hold_data_r <= hold_data_n;
      hold_full_r <= hold_full_n;
      sdata       <= sdata_n;
      svalid      <= svalid_n;
      s_tready    <= tready_n;
      busy        <= busy_n;
`ifdef TX_TLAST_GAP_EN
      hold_last_r <= hold_last_n;
      last_r      <= last_n;
      gap_cnt_r   <= gap_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_axi_tx.sv
// Self-checking bench for axi_tx: per-cycle comparison against a word-level behavioural model,
// an sclk-falling-edge sampler that reconstructs words, and directed literal checks.
module tb_axi_tx;
  localparam int PL = 32;
  localparam int CD = 2;
  localparam int GS = 4;
`ifdef TX_TLAST_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic        aclk     = 1'b0;
  logic        areset   = 1'b1;
  logic [31:0] s_tdata  = 32'h0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast  = 1'b0;
  logic        s_tready, sclk, sdata, svalid, busy;

  axi_tx #(.PACKET_LENGTH(PL), .CLK_DIV(CD), .GAP_SCLKS(GS)) dut (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .sclk(sclk), .sdata(sdata), .svalid(svalid), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model state
  int          k = 0;
  int          bits_left = 0;
  int          gap_left  = 0;
  bit          sclk_e = 1'b0, sdata_e = 1'b0, svalid_e = 1'b0, gap_e = 1'b0;
  bit          tready_e = 1'b0, busy_e = 1'b0;
  bit          hold_full_m = 1'b0, hold_last_m = 1'b0, cur_last = 1'b0;
  logic [31:0] hold_word = 32'h0, cur_word = 32'h0;

  // Sampler state
  logic [31:0] rx_shift = 32'h0;
  logic [31:0] rx_words [16];
  int          bit_n = 0, rx_n = 0;
  int          hi_run = 0, lo_run = 0, last_hi_run = 0, last_lo_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%h, required 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise;
    if (areset) begin
      k = 0; bits_left = 0; gap_left = 0; cur_last = 1'b0;
      sclk_e = 1'b0; sdata_e = 1'b0; svalid_e = 1'b0; gap_e = 1'b0;
      hold_full_m = 1'b0; tready_e = 1'b0; busy_e = 1'b0;
    end else begin
      k++;
      sclk_e = ((k / CD) % 2) == 1;
      rise   = ((k % CD) == 0) && (((k / CD) % 2) == 1);
      if (rise) begin
        if (bits_left > 0) begin
          bits_left--;
          sdata_e = cur_word[bits_left]; svalid_e = 1'b1; gap_e = 1'b0;
        end else begin
          if (GAP_EN && cur_last) begin
            gap_left = GS; cur_last = 1'b0;
          end
          if (gap_left > 0) begin
            gap_left--;
            sdata_e = 1'b0; svalid_e = 1'b0; gap_e = 1'b1;
          end else if (hold_full_m) begin
            cur_word = hold_word; cur_last = hold_last_m; hold_full_m = 1'b0;
            bits_left = PL - 1;
            sdata_e = cur_word[PL-1]; svalid_e = 1'b1; gap_e = 1'b0;
          end else begin
            sdata_e = 1'b0; svalid_e = 1'b0; gap_e = 1'b0;
          end
        end
      end
      if (s_tvalid && tready_e) begin
        hold_full_m = 1'b1; hold_word = s_tdata; hold_last_m = s_tlast;
      end
      tready_e = !hold_full_m;
      busy_e   = svalid_e || gap_e || hold_full_m;
    end
  endtask

  task automatic sample_step();
    if (areset) begin
      bit_n = 0; rx_shift = 32'h0; hi_run = 0; lo_run = 0;
    end else if (svalid) begin
      if (lo_run > 0) last_lo_run = lo_run;
      lo_run = 0;
      hi_run++;
      rx_shift = {rx_shift[30:0], sdata};
      bit_n++;
      if (bit_n == PL) begin
        if (rx_n < 16) rx_words[rx_n] = rx_shift;
        rx_n++;
        bit_n = 0;
      end
    end else begin
      if (hi_run > 0) last_hi_run = hi_run;
      hi_run = 0;
      lo_run++;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit done;
    bit rdy;
    done = 1'b0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      rdy = s_tready;
      @(negedge aclk);
      if (rdy) done = 1'b1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("beat_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_rx(input int target);
    for (int i = 0; i < 2000 && rx_n < target; i++) @(negedge aclk);
    chk("rx_word_count", 32'(rx_n), 32'(target));
  endtask

  initial begin
    int base;
    fork
      forever begin
        @(posedge aclk);
        model_step();
      end
      forever begin
        @(negedge aclk);
        chk("cyc_sclk",   32'(sclk),     32'(sclk_e));
        chk("cyc_sdata",  32'(sdata),    32'(sdata_e));
        chk("cyc_svalid", 32'(svalid),   32'(svalid_e));
        chk("cyc_tready", 32'(s_tready), 32'(tready_e));
        chk("cyc_busy",   32'(busy),     32'(busy_e));
      end
      forever begin
        @(negedge sclk or posedge areset);
        sample_step();
      end
    join_none

    // Reset then idle
    repeat (5) @(negedge aclk);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_svalid", 32'(svalid), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("tready_first_cycle", 32'(s_tready), 32'd1);
    chk("sclk_edge1", 32'(sclk), 32'd0);
    chk("model_tready_pin", 32'(tready_e), 32'd1);
    @(negedge aclk);
    chk("sclk_edge2", 32'(sclk), 32'd1);
    @(negedge aclk);
    chk("sclk_edge3", 32'(sclk), 32'd1);
    @(negedge aclk);
    chk("sclk_edge4", 32'(sclk), 32'd0);
    chk("idle_svalid", 32'(svalid), 32'd0);
    repeat (8) @(negedge aclk);

    // Single beat
    base = rx_n;
    send(32'hA5C3_0F81, 1'b0);
    wait_rx(base + 1);
    repeat (20) @(negedge aclk);
    chk("single_word", rx_words[base], 32'hA5C3_0F81);
    chk("single_periods", 32'(last_hi_run), 32'd32);

    // Back-to-back
    base = rx_n;
    send(32'h0000_0001, 1'b0);
    send(32'h8000_0000, 1'b0);
    wait_rx(base + 2);
    repeat (20) @(negedge aclk);
    chk("b2b_word0", rx_words[base], 32'h0000_0001);
    chk("b2b_word1", rx_words[base+1], 32'h8000_0000);
    chk("b2b_periods", 32'(last_hi_run), 32'd64);

    // tlast gap (or its absence)
    base = rx_n;
    send(32'hFFFF_FFFF, 1'b1);
    send(32'h1234_5678, 1'b0);
    wait_rx(base + 2);
    repeat (20) @(negedge aclk);
    chk("gap_word0", rx_words[base], 32'hFFFF_FFFF);
    chk("gap_word1", rx_words[base+1], 32'h1234_5678);
`ifdef TX_TLAST_GAP_EN
    chk("gap_low_periods", 32'(last_lo_run), 32'd4);
    chk("gap_second_periods", 32'(last_hi_run), 32'd32);
`else
    chk("nogap_periods", 32'(last_hi_run), 32'd64);
`endif

    // Mid-packet reset
    base = rx_n;
    send(32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 400 && bit_n < 11; i++) @(negedge aclk);
    chk("abort_reached_bit10", 32'(bit_n >= 11), 32'd1);
    areset = 1'b1;
    @(negedge aclk);
    chk("abort_svalid", 32'(svalid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    repeat (4) @(negedge aclk);
    send(32'h0000_00FF, 1'b0);
    wait_rx(base + 1);
    repeat (20) @(negedge aclk);
    chk("after_abort_word", rx_words[base], 32'h0000_00FF);
    chk("after_abort_periods", 32'(last_hi_run), 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
